// File: rtl/seg_scan_driver_if.sv
// rtl/seg_scan_driver_if.sv - digit data in, display pins out, for the scan driver
// slave = the scan driver; master = the digit-encoding side / display observer.
interface seg_scan_driver_if #(
   parameter int NUM_DIGITS = 4,
   parameter int BRIGHT_W   = 3
);
   logic                    en;
   logic [7*NUM_DIGITS-1:0] seg_in;
   logic [NUM_DIGITS-1:0]   dp_in;
   logic [NUM_DIGITS-1:0]   blink_mask;
   logic [BRIGHT_W-1:0]     brightness;
   logic [6:0]              cathode;
   logic                    dp_n;
   logic [NUM_DIGITS-1:0]   anode;
   logic                    frame_start;

   modport master (
      output en, seg_in, dp_in, blink_mask, brightness,
      input  cathode, dp_n, anode, frame_start
   );

   modport slave (
      input  en, seg_in, dp_in, blink_mask, brightness,
      output cathode, dp_n, anode, frame_start
   );
endinterface

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - multiplexed seven-segment scan driver with blink, PWM and dead time
// Common-anode, active-low outputs, all registered one cycle after the counter state they show.
module seg_scan_driver #(
   parameter int NUM_DIGITS   = 4,
   parameter int SCAN_DIV     = 50000,
   parameter int DEAD_CYCLES  = 2,
   parameter int BLINK_FRAMES = 64,
   parameter int BRIGHT_W     = 3
) (
   input logic              clk,
   input logic              rst_n,
   seg_scan_driver_if.slave bus
);
   localparam int CW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int DW    = $clog2(NUM_DIGITS);
   localparam int FW    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam int SLICE = (SCAN_DIV - DEAD_CYCLES) >> BRIGHT_W;
   localparam int PW    = BRIGHT_W + CW;

   localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] DEAD_C   = CW'(DEAD_CYCLES);
   localparam logic [DW-1:0] D_LAST   = DW'(NUM_DIGITS - 1);
   localparam logic [DW-1:0] D_ONE    = DW'(1);
   localparam logic [FW-1:0] FC_LAST  = FW'(BLINK_FRAMES - 1);
   localparam logic [FW-1:0] FC_ONE   = FW'(1);
   localparam logic [PW-1:0] SLICE_P  = PW'(SLICE);
   localparam logic [PW-1:0] DEAD_P   = PW'(DEAD_CYCLES);
   localparam logic [NUM_DIGITS-1:0] ANODE_ONE = NUM_DIGITS'(1);

   logic [CW-1:0] cnt;
   logic [DW-1:0] d;
   logic [FW-1:0] fc;
   logic          blink_phase;

   logic                  cnt_wrap, d_wrap, fc_wrap;
   logic [PW-1:0]         on_limit, on_offset;
   logic                  in_window, lit;
   logic [6:0]            sel_seg;
   logic                  sel_dp, sel_blink;
   logic [NUM_DIGITS-1:0] anode_sel;

   assign cnt_wrap = (cnt == CNT_LAST);
   assign d_wrap   = (d == D_LAST);
   assign fc_wrap  = (fc == FC_LAST);

   always_comb begin
      sel_seg   = 7'h7F;
      sel_dp    = 1'b0;
      sel_blink = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (d == DW'(i)) begin
            sel_seg   = bus.seg_in[7*i +: 7];
            sel_dp    = bus.dp_in[i];
            sel_blink = bus.blink_mask[i];
         end
      end
      // Offset is only meaningful past the dead time; the cnt check guards it.
      on_limit  = PW'(bus.brightness) * SLICE_P;
      on_offset = PW'(cnt) - DEAD_P;
      in_window = (cnt >= DEAD_C) && ((&bus.brightness) || (on_offset < on_limit));
      lit       = bus.en && in_window && !(sel_blink && blink_phase);
      anode_sel = ~(ANODE_ONE << d);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt         <= '0;
         d           <= '0;
         fc          <= '0;
         blink_phase <= 1'b0;
      end else if (!bus.en) begin
         cnt         <= '0;
         d           <= '0;
         fc          <= '0;
         blink_phase <= 1'b0;
      end else if (cnt_wrap) begin
         cnt <= '0;
         if (d_wrap) begin
            d <= '0;
            if (fc_wrap) begin
               fc          <= '0;
               blink_phase <= ~blink_phase;
            end else begin
               fc <= fc + FC_ONE;
            end
         end else begin
            d <= d + D_ONE;
         end
      end else begin
         cnt <= cnt + CNT_ONE;
      end
   end

   // Dark releases the anode as well, so no digit ghosts through a stale cathode.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.anode       <= '1;
         bus.cathode     <= 7'h7F;
         bus.dp_n        <= 1'b1;
         bus.frame_start <= 1'b0;
      end else begin
         bus.anode       <= lit ? anode_sel : '1;
         bus.cathode     <= lit ? sel_seg : 7'h7F;
         bus.dp_n        <= lit ? ~sel_dp : 1'b1;
         bus.frame_start <= bus.en && (cnt == '0) && (d == '0);
      end
   end
endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Parametrised multiplexed seven-segment scan driver. It replaces the fixed four-digit display stage of the stopwatch and generates its own scan and blink timing from a single clock, so no external blink clock is needed. It adds per-digit blink masks, a decimal point, PWM brightness and an anti-ghosting dead time between digits. It sits between the digit-encoding logic and the board's common-anode display pins.

## Interface
- NUM_DIGITS, 4: digits scanned, legal range 2..8.
- SCAN_DIV, 50000: clk cycles per digit slot. Must be ≥ DEAD_CYCLES+2^BRIGHT_W.
- DEAD_CYCLES, 2: dark cycles at the start of every slot, ≥1.
- BLINK_FRAMES, 64: full scan frames per blink half-period, ≥1.
- BRIGHT_W, 3: width of the brightness input.

- clk, in, 1: system clock.
- rst_n, in, 1: reset. One clock; reset is asynchronous and active-low.
- en, in, 1: display enable.
- seg_in, in, 7*NUM_DIGITS: active-low segment patterns, digit i at [7i+6:7i].
- dp_in, in, NUM_DIGITS: 1 = light the decimal point of digit i.
- blink_mask, in, NUM_DIGITS: 1 = digit i blinks.
- brightness, in, BRIGHT_W: 0 = dark, all-ones = full on-window.
- cathode, out, 7: active-low segments, registered.
- dp_n, out, 1: active-low decimal point, registered.
- anode, out, NUM_DIGITS: active-low digit select (anode[i] = digit i), registered, at most one bit low.
- frame_start, out, 1: one-cycle pulse while digit 0's slot begins.

## Operation
- Counters:
  - slot counter cnt runs 0..SCAN_DIV-1.
  - On wrap, digit index d advances 0..NUM_DIGITS-1 and wraps to 0.
  - On d wrap, frame counter fc advances 0..BLINK_FRAMES-1.
  - On fc wrap, blink_phase toggles (0 = visible, 1 = blink-off).
- Localparam SLICE = (SCAN_DIV-DEAD_CYCLES) >> BRIGHT_W.
- Digit d is lit when all of the following hold:
  - cnt ≥ DEAD_CYCLES.
  - Either brightness is all-ones, or (cnt-DEAD_CYCLES) < brightness*SLICE.
  - Not (blink_mask[d] and blink_phase).
  - en=1.
- Lit output: anode has only bit d low, cathode = seg_in[d], dp_n = ~dp_in[d].
- Dark output (any dark condition): anode all ones, cathode 7'h7F, dp_n 1. The anode is released, not just the cathode.
- en=0: counters and blink_phase clear synchronously to 0 and hold. Outputs are dark. On re-enable, scanning restarts at digit 0, cnt 0, visible phase.
- frame_start is high for the one output cycle computed from state d=0, cnt=0.
- Arithmetic:
  - brightness*SLICE is sized to hold (2^BRIGHT_W-1)*SLICE without overflow.
  - cnt is sized by $clog2(SCAN_DIV), fc by $clog2(BLINK_FRAMES) (minimum 1 bit).
- Reset (async, rst_n low):
  - cnt, d, fc and blink_phase are 0.
  - anode all ones, cathode 7'h7F, dp_n 1, frame_start 0.

## Timing
- All outputs are registered. The output at edge k reflects counter state and inputs sampled at edge k-1, a latency of 1 cycle.
- Changes to seg_in, dp_in, blink_mask, brightness or en appear at the next edge. No other input qualification applies.
- Slot layout: DEAD_CYCLES dark cycles, then the PWM on-window, then dark for the rest of the slot.
- Digit transitions therefore always pass through at least DEAD_CYCLES all-dark cycles.
- Frame = NUM_DIGITS*SCAN_DIV cycles. Blink period = 2*BLINK_FRAMES frames.
- blink_phase toggles on the same edge that d wraps to 0. The first slot of the new frame already uses the new phase.
- Reset mid-slot: outputs go dark immediately, asynchronously. The first lit cycle comes DEAD_CYCLES+1 edges after rst_n deasserts.

## Test plan
Bench parameters unless stated: NUM_DIGITS=4, SCAN_DIV=8, DEAD_CYCLES=2, BLINK_FRAMES=2, BRIGHT_W=2, which gives SLICE=1.

- Reset:
  - Stimulus: assert rst_n mid-slot while digit 2 is lit.
  - Response: in the same cycle anode=4'hF, cathode=7'h7F, dp_n=1, frame_start=0.
  - After release, digit 0 is lit from the 3rd edge for 6 cycles.
- Scan order:
  - Stimulus: brightness=3, en=1, seg_in={7'h12,7'h4F,7'h24,7'h01}.
  - Response: anode steps 1110→1101→1011→0111 with cathode 7'h01, 7'h24, 7'h4F, 7'h12 respectively.
  - Each digit is lit 6 of 8 cycles with 2 all-dark cycles between digits. frame_start pulses once every 32 cycles.
- Blink:
  - Stimulus: blink_mask=4'b0011.
  - Response: frames 0–1 show all digits lit. Frames 2–3 keep digits 0 and 1 dark (anode all ones) while digits 2 and 3 stay lit. The pattern repeats every 128 cycles.
- Brightness:
  - brightness=1 → each digit is lit exactly 1 cycle per slot, at cnt=2.
  - brightness=2 → lit at cnt=2,3.
  - brightness=0 → anode stays 4'hF for a whole frame.
- Decimal point:
  - Stimulus: dp_in=4'b0100.
  - Response: dp_n=0 only in cycles with anode=4'b1011; otherwise dp_n=1.
- Enable:
  - Stimulus: drop en while digit 1 is lit in blink-off phase.
  - Response: outputs go dark on the next edge.
  - Raise en again → digit 0 is lit 3 edges later, with blink-masked digits visible.
